regfile_multiport: RTL
======================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL provide parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL provide parameter SCAN_DIV, default 4, clocks per scan step, at least 1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ReadRegs  input  NUM_RD*ADDR_W  packed read addresses; port k uses slice k.
REQ-008 ReadData  output  NUM_RD*DATA_W  packed read data; port k uses slice k.
REQ-009 RegWrite  input  1  write enable.
REQ-010 WriteReg  input  ADDR_W  write address.
REQ-011 WriteData  input  DATA_W  write data.
REQ-012 Clear  input  1  request to zero the whole file.
REQ-013 Busy  output  1  clear sequence in progress.
REQ-014 ClearDone  output  1  one-cycle pulse when the clear sequence completes.
REQ-015 switch  input  ADDR_W  display register select when scan is off.
REQ-016 ScanEn  input  1  auto-cycle the display index.
REQ-017 DispIdx  output  ADDR_W  index currently shown.
REQ-018 ssd_out  output  DATA_W  registered contents of register DispIdx.

Function
REQ-019 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-020 Read ports SHALL be combinational from array contents: no latency, all ports independent.
REQ-021 When RegWrite=1, Busy=0 and WriteReg!=0, the rising edge SHALL store WriteData at WriteReg.
REQ-022 The FSM SHALL have two states, IDLE and CLEAR.
REQ-023 In IDLE, Clear=1 SHALL enter CLEAR and load index 1; a same-cycle write SHALL be dropped, so Clear wins.
REQ-024 In CLEAR, each cycle SHALL zero register[index] and increment index; after index DEPTH-1 is zeroed, the FSM SHALL return to IDLE and pulse ClearDone for exactly one cycle.
REQ-025 Clear SHALL therefore occupy DEPTH-1 cycles; Busy=1 exactly while in CLEAR.
REQ-026 While Busy=1, RegWrite SHALL be ignored and Clear SHALL be ignored (no restart).
REQ-027 While Busy=1, reads SHALL return current array contents, so some registers are cleared and some are not yet cleared.
REQ-028 With ScanEn=0, DispIdx SHALL equal switch, registered with 1-cycle latency.
REQ-029 With ScanEn=1, DispIdx SHALL advance by 1 every SCAN_DIV cycles, wrapping DEPTH-1 -> 0.
REQ-030 The prescaler SHALL reset to 0 when ScanEn deasserts.
REQ-031 Re-enabling scan SHALL start from the current DispIdx.
REQ-032 ssd_out SHALL equal register[DispIdx] as of the previous edge (1-cycle latency), including bypass per REQ-036.

Reset
REQ-033 rst_n=0 SHALL immediately zero all DEPTH registers, ssd_out, DispIdx, Busy, ClearDone, the index counter and the prescaler, and force IDLE.
REQ-034 Reset asserted during CLEAR SHALL abort the sequence without a ClearDone pulse.
REQ-035 After deassertion, the first active edge SHALL behave as in IDLE.

Configuration
REQ-036 Macro RF_BYPASS_EN defined: a read port whose address equals WriteReg (nonzero), while a write is accepted that cycle, SHALL return WriteData combinationally (write-through).
REQ-037 RF_BYPASS_EN undefined: reads SHALL return the old value until after the edge; there is no bypass logic.

Verification
REQ-038 Reset, then write 0xDEADBEEF to reg 5 and read reg 5 on port 0 and reg 0 on port 1 -> 0xDEADBEEF and 0x00000000.
REQ-039 Write 0x12345678 to reg 0 -> all ports reading 0 return 0.
REQ-040 With RF_BYPASS_EN, RegWrite=1, WriteReg=7, WriteData=0xA5A5A5A5, ReadRegs port 0=7 in the same cycle -> ReadData port 0 = 0xA5A5A5A5 before the edge; without the macro -> old value 0.
REQ-041 Fill regs 1..31 with their index, pulse Clear -> Busy high 31 cycles, ClearDone one pulse, all reads 0; a write issued mid-clear is lost.
REQ-042 ScanEn=1, SCAN_DIV=4 -> DispIdx steps 0,1,2... every 4 cycles, wraps 31->0, and ssd_out tracks it with 1-cycle lag.
REQ-043 Assert rst_n=0 at clear cycle 10 -> Busy=0, no ClearDone, all regs 0, FSM IDLE.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with a sequenced clear and a scanning display tap.
// Define RF_BYPASS_EN to forward same-cycle write data to read ports and the display tap.
module regfile_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   ReadRegs,
  output logic [NUM_RD*DATA_W-1:0]   ReadData,
  input  logic                       RegWrite,
  input  logic [ADDR_W-1:0]          WriteReg,
  input  logic [DATA_W-1:0]          WriteData,
  input  logic                       Clear,
  output logic                       Busy,
  output logic                       ClearDone,
  input  logic [ADDR_W-1:0]          switch,
  input  logic                       ScanEn,
  output logic [ADDR_W-1:0]          DispIdx,
  output logic [DATA_W-1:0]          ssd_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [ADDR_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] ssd_q, ssd_d;
  logic              we_c;
  logic [ADDR_W-1:0] rd_addr_c;

  // A write lands only when idle, not pre-empted by Clear, and not aimed at register 0.
  assign we_c = (state_q == IDLE) && !Clear && RegWrite && (WriteReg != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Clear) begin
          state_d = CLEAR;
          idx_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_comb begin
    regs_d = regs_q;
    if (we_c) begin
      regs_d[WriteReg] = WriteData;
    end
    if (state_q == CLEAR) begin
      regs_d[idx_q] = '0;
    end
  end

  // Read ports: register 0 is hard-wired to zero.
  always_comb begin
    ReadData  = '0;
    rd_addr_c = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_addr_c = ReadRegs[k*ADDR_W +: ADDR_W];
      if (rd_addr_c != '0) begin
        ReadData[k*DATA_W +: DATA_W] = regs_q[rd_addr_c];
`ifdef RF_BYPASS_EN
        if (we_c && (rd_addr_c == WriteReg)) begin
          ReadData[k*DATA_W +: DATA_W] = WriteData;
        end
`endif
      end
    end
  end

  // Display index: follows switch, or steps every SCAN_DIV cycles when scanning.
  always_comb begin
    disp_d  = disp_q;
    presc_d = presc_q;
    if (!ScanEn) begin
      disp_d  = switch;
      presc_d = '0;
    end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      disp_d  = disp_q + ADDR_W'(1);
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  always_comb begin
    ssd_d = regs_q[disp_q];
`ifdef RF_BYPASS_EN
    if (we_c && (WriteReg == disp_q)) begin
      ssd_d = WriteData;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      disp_q  <= '0;
      ssd_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      disp_q  <= disp_d;
      ssd_q   <= ssd_d;
    end
  end

  assign Busy      = busy_q;
  assign ClearDone = done_q;
  assign DispIdx   = disp_q;
  assign ssd_out   = ssd_q;

endmodule
